// File: rtl/ram_line_arbiter.sv
// Line-wide RAM arbiter for I-cache read, D-cache read and D-cache write-back.
// One transaction at a time, single-cycle completion pulse, I-side starvation guard and BUSY timeout.
module ram_line_arbiter #(
  parameter int LINE_W       = 128,
  parameter int ADDR_W       = 26,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqI_cache,
  input  logic [ADDR_W-1:0] reqAddrI_mem,
  input  logic              reqD_cache,
  input  logic [ADDR_W-1:0] reqAddrD_mem,
  input  logic              reqD_cache_write,
  input  logic [ADDR_W-1:0] reqAddrD_write_mem,
  input  logic [LINE_W-1:0] data_from_cache,
  output logic [LINE_W-1:0] data_to_cache,
  output logic              read_ready_for_icache,
  output logic              read_ready_for_dcache,
  output logic              written_data_ack,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_wdata,
  input  logic [LINE_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              busy,
  output logic              mem_error
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {G_NONE = 2'd0, G_I = 2'd1, G_D = 2'd2, G_W = 2'd3} grant_t;

  state_t            state_r, state_s;
  grant_t            grant_r, grant_s, sel_s;
  logic [SW-1:0]     starve_r, starve_s;
  logic [TW-1:0]     tcnt_r, tcnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [LINE_W-1:0] wdata_r, wdata_s, rdata_r, rdata_s;
  logic              we_r, we_s, req_r, req_s, err_r, err_s, busy_r;
  logic              ack_i_r, ack_i_s, ack_d_r, ack_d_s, ack_w_r, ack_w_s;
  logic              done_s;

  // Grant selection: forced I once the D side has used up its allowance
  always_comb begin
    sel_s = G_NONE;
    if (reqI_cache && (starve_r == STARVE_MAX)) begin
      sel_s = G_I;
    end else if (reqD_cache_write) begin
      sel_s = G_W;
    end else if (reqD_cache) begin
      sel_s = G_D;
    end else if (reqI_cache) begin
      sel_s = G_I;
    end else begin
      sel_s = G_NONE;
    end
  end

  assign done_s = ram_ack || (tcnt_r == TIMEOUT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (sel_s != G_NONE) state_s = BUSY; else state_s = IDLE;
      BUSY:    if (done_s) state_s = RESP; else state_s = BUSY;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    grant_s  = grant_r;
    addr_s   = addr_r;
    we_s     = we_r;
    wdata_s  = wdata_r;
    rdata_s  = rdata_r;
    req_s    = 1'b0;
    err_s    = err_r;
    starve_s = starve_r;
    tcnt_s   = tcnt_r;
    ack_i_s  = 1'b0;
    ack_d_s  = 1'b0;
    ack_w_s  = 1'b0;
    case (state_r)
      IDLE: begin
        tcnt_s = '0;
        if ((sel_s == G_I) || !reqI_cache) begin
          starve_s = '0;
        end else if ((sel_s != G_NONE) && (starve_r != STARVE_MAX)) begin
          starve_s = starve_r + SW'(1);
        end else begin
          starve_s = starve_r;
        end
        case (sel_s)
          G_W: begin
            grant_s = G_W; req_s = 1'b1; addr_s = reqAddrD_write_mem;
            we_s = 1'b1; wdata_s = data_from_cache;
          end
          G_D: begin
            grant_s = G_D; req_s = 1'b1; addr_s = reqAddrD_mem;
            we_s = 1'b0; wdata_s = '0;
          end
          G_I: begin
            grant_s = G_I; req_s = 1'b1; addr_s = reqAddrI_mem;
            we_s = 1'b0; wdata_s = '0;
          end
          default: grant_s = grant_r;
        endcase
      end
      BUSY: begin
        if (ram_ack) begin
          if (grant_r != G_W) rdata_s = ram_rdata; else rdata_s = rdata_r;
        end else if (tcnt_r == TIMEOUT_LAST) begin
          err_s   = 1'b1;
          rdata_s = '0;
        end else begin
          req_s  = 1'b1;
          tcnt_s = tcnt_r + TW'(1);
        end
        if (done_s) begin
          case (grant_r)
            G_I:     ack_i_s = 1'b1;
            G_D:     ack_d_s = 1'b1;
            G_W:     ack_w_s = 1'b1;
            default: ack_i_s = 1'b0;
          endcase
        end else begin
          ack_i_s = 1'b0;
        end
      end
      RESP:    tcnt_s = '0;
      default: tcnt_s = '0;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_r  <= G_NONE;
      addr_r   <= '0;
      we_r     <= 1'b0;
      wdata_r  <= '0;
      rdata_r  <= '0;
      req_r    <= 1'b0;
      err_r    <= 1'b0;
      starve_r <= '0;
      tcnt_r   <= '0;
      ack_i_r  <= 1'b0;
      ack_d_r  <= 1'b0;
      ack_w_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      grant_r  <= grant_s;
      addr_r   <= addr_s;
      we_r     <= we_s;
      wdata_r  <= wdata_s;
      rdata_r  <= rdata_s;
      req_r    <= req_s;
      err_r    <= err_s;
      starve_r <= starve_s;
      tcnt_r   <= tcnt_s;
      ack_i_r  <= ack_i_s;
      ack_d_r  <= ack_d_s;
      ack_w_r  <= ack_w_s;
      busy_r   <= (state_s != IDLE);
    end
  end

  assign data_to_cache         = rdata_r;
  assign read_ready_for_icache = ack_i_r;
  assign read_ready_for_dcache = ack_d_r;
  assign written_data_ack      = ack_w_r;
  assign ram_req               = req_r;
  assign ram_we                = we_r;
  assign ram_addr              = addr_r;
  assign ram_wdata             = wdata_r;
  assign busy                  = busy_r;
  assign mem_error             = err_r;

endmodule

// File: tb/tb_ram_line_arbiter.sv
// Bench for ram_line_arbiter: directed scenarios plus randomized requesters, checked
// against a transaction-level model of grant priority, starvation and timeout.
module tb_ram_line_arbiter;
  localparam int LW = 128;
  localparam int AW = 26;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqI_cache, reqD_cache, reqD_cache_write;
  logic [AW-1:0] reqAddrI_mem, reqAddrD_mem, reqAddrD_write_mem;
  logic [LW-1:0] data_from_cache, data_to_cache, ram_wdata, ram_rdata;
  logic          read_ready_for_icache, read_ready_for_dcache, written_data_ack;
  logic          ram_req, ram_we, ram_ack, busy, mem_error;
  logic [AW-1:0] ram_addr;

  ram_line_arbiter dut (
    .clk(clk), .reset(reset),
    .reqI_cache(reqI_cache), .reqAddrI_mem(reqAddrI_mem),
    .reqD_cache(reqD_cache), .reqAddrD_mem(reqAddrD_mem),
    .reqD_cache_write(reqD_cache_write), .reqAddrD_write_mem(reqAddrD_write_mem),
    .data_from_cache(data_from_cache), .data_to_cache(data_to_cache),
    .read_ready_for_icache(read_ready_for_icache), .read_ready_for_dcache(read_ready_for_dcache),
    .written_data_ack(written_data_ack),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .busy(busy), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef enum {W_I, W_D, W_W} who_t;

  int            pass_cnt = 0;
  int            total = 0;
  int            starve_m = 0;
  logic          err_m = 1'b0;
  logic [LW-1:0] data_m = '0;
  logic [2:0]    got_pulse;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One whole transaction from IDLE; lat = BUSY cycle carrying ram_ack, 0 = never acked
  task automatic serve(input int lat, input logic [LW-1:0] rd);
    who_t          g;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [LW-1:0] ewd;
    logic [2:0]    ep;
    int            busy_n;
    int            bc;
    if (reqI_cache && starve_m == 4) g = W_I;
    else if (reqD_cache_write) g = W_W;
    else if (reqD_cache) g = W_D;
    else g = W_I;
    if (g == W_I || !reqI_cache) starve_m = 0;
    else if (starve_m < 4) starve_m++;
    case (g)
      W_W:     begin ea = reqAddrD_write_mem; ewe = 1'b1; ep = 3'b001; end
      W_D:     begin ea = reqAddrD_mem;       ewe = 1'b0; ep = 3'b010; end
      default: begin ea = reqAddrI_mem;       ewe = 1'b0; ep = 3'b100; end
    endcase
    ewd = data_from_cache;
    tick();
    check("grant_req", ram_req, 1);
    check("grant_addr", ram_addr, ea);
    check("grant_we", ram_we, ewe);
    if (ewe) check("grant_wdata", ram_wdata, ewd);
    busy_n = 0;
    bc = 1;
    while (1) begin
      busy_n += busy;
      if (bc == lat) begin
        ram_rdata = rd;
        ram_ack = 1'b1;
        tick();
        ram_ack = 1'b0;
        ram_rdata = rand128();
        break;
      end else if (lat == 0 && bc == 64) begin
        tick();
        break;
      end else begin
        tick();
        check("busy_hold", {ram_req, ram_we, ram_addr}, {1'b1, ewe, ea});
      end
      bc++;
    end
    busy_n += busy;
    check("busy_cycles", busy_n, (lat == 0) ? 65 : lat + 1);
    if (lat == 0) begin
      err_m = 1'b1;
      data_m = '0;
    end else if (g != W_W) begin
      data_m = rd;
    end
    got_pulse = {read_ready_for_icache, read_ready_for_dcache, written_data_ack};
    check("resp_pulse", got_pulse, ep);
    check("resp_data", data_to_cache, data_m);
    check("resp_req_low", ram_req, 0);
    check("mem_error", mem_error, err_m);
    case (g)
      W_W:     reqD_cache_write = 1'b0;
      W_D:     reqD_cache = 1'b0;
      default: reqI_cache = 1'b0;
    endcase
    tick();
    check("idle_after_resp", {busy, read_ready_for_icache, read_ready_for_dcache, written_data_ack}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    reqI_cache = 1'b0; reqD_cache = 1'b0; reqD_cache_write = 1'b0;
    reqAddrI_mem = '0; reqAddrD_mem = '0; reqAddrD_write_mem = '0;
    data_from_cache = '0; ram_rdata = '0; ram_ack = 1'b0;
    #12;
    check("reset_outputs", {ram_req, ram_we, ram_addr, busy, mem_error, read_ready_for_icache,
                            read_ready_for_dcache, written_data_ack}, 0);
    check("reset_data", data_to_cache, 0);
    check("reset_wdata", ram_wdata, 0);
    tick();
    reset = 1'b1;

    // single I read, ack in third BUSY cycle
    reqI_cache = 1'b1; reqAddrI_mem = 26'h0000123;
    serve(3, 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF);
    check("i_read_data", data_to_cache, 128'hDEADBEEF_0123_4567_89AB_CDEF_DEADBEEF);

    // write-back beats D read
    reqD_cache_write = 1'b1; reqAddrD_write_mem = 26'h10; data_from_cache = {16{8'hA5}};
    reqD_cache = 1'b1; reqAddrD_mem = 26'h0002040;
    serve(2, rand128());
    check("wb_first", got_pulse, 3'b001);
    serve(1, rand128());
    check("dread_second", got_pulse, 3'b010);

    // starvation guard: four D grants, then I, then D again
    reqI_cache = 1'b1; reqAddrI_mem = 26'h0000777;
    for (int i = 0; i < 5; i++) begin
      if (!reqD_cache) begin reqD_cache = 1'b1; reqAddrD_mem = AW'($urandom()); end
      serve(1, rand128());
      check("starve_order", got_pulse, (i < 4) ? 3'b010 : 3'b100);
    end
    serve(1, rand128());
    check("d_resumes", got_pulse, 3'b010);

    // timeout abort, then mem_error stays set
    reqD_cache = 1'b1; reqAddrD_mem = 26'h0000abc;
    serve(0, '0);
    reqI_cache = 1'b1; reqAddrI_mem = 26'h0000321;
    serve(1, rand128());
    check("mem_error_sticky", mem_error, 1);

    // reset in second BUSY cycle
    reqI_cache = 1'b1; reqAddrI_mem = 26'h0001555;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("async_reset_ctl", {ram_req, ram_we, ram_addr, busy, mem_error, read_ready_for_icache,
                              read_ready_for_dcache, written_data_ack}, 0);
    check("async_reset_data", {data_to_cache, ram_wdata}, 0);
    tick();
    check("reset_no_pulse", {read_ready_for_icache, read_ready_for_dcache, written_data_ack}, 0);
    reset = 1'b1;
    starve_m = 0; err_m = 1'b0; data_m = '0;
    serve(2, rand128());
    check("regrant_after_reset", got_pulse, 3'b100);

    // back-to-back I reads, ack in first BUSY cycle
    for (int i = 0; i < 3; i++) begin
      reqI_cache = 1'b1; reqAddrI_mem = AW'($urandom());
      serve(1, rand128());
    end

    // late ack in IDLE is ignored
    ram_rdata = rand128();
    ram_ack = 1'b1;
    if (!reqI_cache) starve_m = 0;
    tick();
    ram_ack = 1'b0;
    check("late_ack_ignored", {busy, ram_req, read_ready_for_icache, read_ready_for_dcache,
                               written_data_ack}, 0);
    check("late_ack_data_hold", data_to_cache, data_m);

    // randomized requesters
    for (int n = 0; n < 30; n++) begin
      if (!reqI_cache && $urandom_range(0, 1) == 1) begin
        reqI_cache = 1'b1; reqAddrI_mem = AW'($urandom());
      end
      if (!reqD_cache && $urandom_range(0, 1) == 1) begin
        reqD_cache = 1'b1; reqAddrD_mem = AW'($urandom());
      end
      if (!reqD_cache_write && $urandom_range(0, 2) == 2) begin
        reqD_cache_write = 1'b1; reqAddrD_write_mem = AW'($urandom()); data_from_cache = rand128();
      end
      if (!reqI_cache && !reqD_cache && !reqD_cache_write) begin
        reqI_cache = 1'b1; reqAddrI_mem = AW'($urandom());
      end
      serve($urandom_range(1, 5), rand128());
    end
    for (int k = 0; k < 3; k++) begin
      if (reqI_cache || reqD_cache || reqD_cache_write) serve(1, rand128());
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
